// File: rtl/flu_edit_pkg.sv
// Shared defaults and the offset FIFO entry layout for the FLU edit-offset attach block.
package flu_edit_pkg;
    localparam int DEF_DATA_W    = 256;
    localparam int DEF_EOP_POS_W = 5;
    localparam int DEF_SOP_POS_W = 2;
    localparam int DEF_OFFSET_W  = 10;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int STALL_CNT_W   = 16;

    typedef struct packed {
        logic [DEF_OFFSET_W-1:0] offset;
        logic                    en;
    } off_entry_t;
endpackage

// File: rtl/flu_edit_offset_attach_if.sv
// FLU input stream, offset stream and FLU edit output grouped as one bus.
interface flu_edit_offset_attach_if
    import flu_edit_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_W,
    parameter int EOP_POS_WIDTH = DEF_EOP_POS_W,
    parameter int SOP_POS_WIDTH = DEF_SOP_POS_W,
    parameter int OFFSET_WIDTH  = DEF_OFFSET_W
);
    logic [DATA_WIDTH-1:0]    RX_DATA;
    logic [SOP_POS_WIDTH-1:0] RX_SOP_POS;
    logic [EOP_POS_WIDTH-1:0] RX_EOP_POS;
    logic                     RX_SOP, RX_EOP, RX_SRC_RDY, RX_DST_RDY;
    logic [OFFSET_WIDTH-1:0]  OFF_DATA;
    logic                     OFF_EN, OFF_VLD, OFF_RDY;
    logic [DATA_WIDTH-1:0]    TX_DATA;
    logic [SOP_POS_WIDTH-1:0] TX_SOP_POS;
    logic [EOP_POS_WIDTH-1:0] TX_EOP_POS;
    logic                     TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY;
    logic [OFFSET_WIDTH-1:0]  TX_OFFSET;
    logic                     TX_EDIT_EN;
    logic [STALL_CNT_W-1:0]   STALL_CNT;

    modport master (
        output RX_DATA, RX_SOP_POS, RX_EOP_POS, RX_SOP, RX_EOP, RX_SRC_RDY,
        output OFF_DATA, OFF_EN, OFF_VLD, TX_DST_RDY,
        input  RX_DST_RDY, OFF_RDY, TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP,
        input  TX_SRC_RDY, TX_OFFSET, TX_EDIT_EN, STALL_CNT
    );
    modport slave (
        input  RX_DATA, RX_SOP_POS, RX_EOP_POS, RX_SOP, RX_EOP, RX_SRC_RDY,
        input  OFF_DATA, OFF_EN, OFF_VLD, TX_DST_RDY,
        output RX_DST_RDY, OFF_RDY, TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP,
        output TX_SRC_RDY, TX_OFFSET, TX_EDIT_EN, STALL_CNT
    );
endinterface

// File: rtl/flu_edit_offset_fifo.sv
// Small synchronous FIFO for per-packet edit offsets; ready is held low until
// the first clock after reset release.
module flu_edit_offset_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             init_done;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign ready    = init_done && (count != FULL_CNT);
    assign do_push  = push && ready;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/flu_edit_offset_attach.sv
// Attaches a queued edit offset to each FLU packet's SOP word (1-cycle register stage).
// Optional FLU_EDIT_OFFSET_DEFAULT_EN: SOP with no offset passes with offset 0 / edit disabled.
module flu_edit_offset_attach
    import flu_edit_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_W,
    parameter int EOP_POS_WIDTH = DEF_EOP_POS_W,
    parameter int SOP_POS_WIDTH = DEF_SOP_POS_W,
    parameter int OFFSET_WIDTH  = DEF_OFFSET_W,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input logic CLK,
    input logic RESET,
    flu_edit_offset_attach_if.slave bus
);
    logic                     out_free, xfer, pop, rx_rdy, fifo_empty, stall_hit;
    logic [OFFSET_WIDTH:0]    head, sop_entry;
    logic                     tx_vld, tx_sop, tx_eop, tx_en;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic [SOP_POS_WIDTH-1:0] tx_sop_pos;
    logic [EOP_POS_WIDTH-1:0] tx_eop_pos;
    logic [OFFSET_WIDTH-1:0]  tx_off;
    logic [STALL_CNT_W-1:0]   stall_cnt;

    flu_edit_offset_fifo #(.WIDTH(OFFSET_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK), .rst_n(RESET),
        .push(bus.OFF_VLD), .push_data({bus.OFF_DATA, bus.OFF_EN}),
        .pop(pop), .pop_data(head),
        .empty(fifo_empty), .ready(bus.OFF_RDY)
    );

    assign out_free  = !tx_vld || bus.TX_DST_RDY;
    assign xfer      = bus.RX_SRC_RDY && rx_rdy;
    // Same condition in both builds: with the default-enable build it counts substitutions.
    assign stall_hit = bus.RX_SRC_RDY && bus.RX_SOP && out_free && fifo_empty;

`ifdef FLU_EDIT_OFFSET_DEFAULT_EN
    assign rx_rdy    = out_free;
    assign pop       = xfer && bus.RX_SOP && !fifo_empty;
    assign sop_entry = fifo_empty ? '0 : head;
`else
    assign rx_rdy    = out_free && (!bus.RX_SOP || !fifo_empty);
    assign pop       = xfer && bus.RX_SOP;
    assign sop_entry = head;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_vld     <= 1'b0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
            tx_data    <= '0;
            tx_sop_pos <= '0;
            tx_eop_pos <= '0;
            tx_off     <= '0;
            tx_en      <= 1'b0;
        end else if (xfer) begin
            tx_vld     <= 1'b1;
            tx_sop     <= bus.RX_SOP;
            tx_eop     <= bus.RX_EOP;
            tx_data    <= bus.RX_DATA;
            tx_sop_pos <= bus.RX_SOP_POS;
            tx_eop_pos <= bus.RX_EOP_POS;
            // Shared EOP+SOP words also land here: the offset belongs to the new packet.
            if (bus.RX_SOP) begin
                tx_off <= sop_entry[OFFSET_WIDTH:1];
                tx_en  <= sop_entry[0];
            end
        end else if (bus.TX_DST_RDY) begin
            tx_vld <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                      stall_cnt <= '0;
        else if (stall_hit && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.RX_DST_RDY = rx_rdy;
    assign bus.TX_SRC_RDY = tx_vld;
    assign bus.TX_SOP     = tx_sop;
    assign bus.TX_EOP     = tx_eop;
    assign bus.TX_DATA    = tx_data;
    assign bus.TX_SOP_POS = tx_sop_pos;
    assign bus.TX_EOP_POS = tx_eop_pos;
    assign bus.TX_OFFSET  = tx_off;
    assign bus.TX_EDIT_EN = tx_en;
    assign bus.STALL_CNT  = stall_cnt;
endmodule
